// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the fetch stage.
// Holds the PC, produces PC+INSTR_BYTES, computes branch and jump redirect
// targets, and issues fetch requests under a valid/ready handshake. The
// sequencer also supports stall, halt/resume and flush-style redirects.
// Optional feature macro: ALIGN_CHECK_EN. When it is defined, a misaligned
// redirect target traps and the trap is sticky until reset. When it is
// undefined, the target is aligned down and loaded.
// INSTR_BYTES is assumed to be a power of two, so alignment is a low-bit mask.
module pc_sequencer #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               INSTR_BYTES = 4,
  parameter int               IMM_SHIFT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_pc,
  input  logic [WIDTH-1:0] sign_ext_imm,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             req_ready,
  output logic             req_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect,
  output logic             misalign_trap
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;
  localparam logic [1:0] ST_TRAP = 2'd3;

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INSTR_BYTES - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] redirect_target;
  logic             redirect_req;
  logic             redirect_next;
  logic             trap_next;

  // The shifted immediate is truncated to WIDTH and all sums wrap modulo 2^WIDTH.
  assign pc_plus4        = pc + STEP;
  assign branch_target   = branch_pc + STEP + (sign_ext_imm << IMM_SHIFT);
  assign redirect_target = jump ? jump_target : branch_target;
  assign redirect_req    = jump || branch_taken;

`ifdef ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |(redirect_target & ALIGN_MASK);
`endif

  // Next-state, next-PC and redirect-pulse selection. Priority in RUN is
  // jump > branch > hold > advance.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    state_next    = state;
    pc_next       = pc;
    redirect_next = 1'b0;
    trap_next     = misalign_trap;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        // Halt takes effect after this cycle. A redirect or an accepted
        // fetch in the same cycle still updates pc.
        if (halt) state_next = ST_HALT;
        if (redirect_req) begin
`ifdef ALIGN_CHECK_EN
          if (misaligned) begin
            state_next = ST_TRAP;
            trap_next  = 1'b1;
          end else begin
            pc_next       = redirect_target;
            redirect_next = 1'b1;
          end
`else
          pc_next       = redirect_target & ~ALIGN_MASK;
          redirect_next = 1'b1;
`endif
        end else if (req_valid && req_ready && !stall) begin
          pc_next = pc_plus4;
        end
      end
      ST_HALT: if (resume) state_next = ST_RUN;
      ST_TRAP: state_next = ST_TRAP;
    endcase
  end

  // State registers. Reset overrides every other input in its cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (reset) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      req_valid <= 1'b0;
      redirect  <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      req_valid <= (state_next == ST_RUN);
      redirect  <= redirect_next;
    end
  end

`ifdef ALIGN_CHECK_EN
  // Sticky misalignment trap flag. Only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) misalign_trap <= 1'b0;
    else       misalign_trap <= trap_next;
  end
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scenario-driven bench for pc_sequencer (default parameters).
// Each task queues its expected register values as it drives stimulus, then
// compares the DUT outputs 1 ns after the edge. Expectations for the
// misalignment scenario follow the ALIGN_CHECK_EN macro.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, halt, resume, branch_taken, jump, req_ready;
  logic [31:0] branch_pc, sign_ext_imm, jump_target;
  logic        req_valid, redirect, misalign_trap;
  logic [31:0] pc, pc_plus4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, stall, halt, resume, br;
    logic [31:0] bpc, imm;
    logic        jump;
    logic [31:0] jt;
    logic        ready;
  } stim_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        rv, rd, tr;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer #(
    .WIDTH(32), .RESET_PC(32'h0), .INSTR_BYTES(4), .IMM_SHIFT(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .branch_taken(branch_taken), .branch_pc(branch_pc), .sign_ext_imm(sign_ext_imm),
    .jump(jump), .jump_target(jump_target), .req_ready(req_ready),
    .req_valid(req_valid), .pc(pc), .pc_plus4(pc_plus4), .redirect(redirect),
    .misalign_trap(misalign_trap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic stim_t st(logic rst, logic stl, logic hlt, logic res, logic br,
                               logic [31:0] bpc, logic [31:0] imm, logic jmp,
                               logic [31:0] jt, logic rdy);
    stim_t s;
    s.rst = rst; s.stall = stl; s.halt = hlt; s.resume = res; s.br = br;
    s.bpc = bpc; s.imm = imm; s.jump = jmp; s.jt = jt; s.ready = rdy;
    return s;
  endfunction

  function automatic exp_t ex(string name, logic [31:0] p, logic rv, logic rd, logic tr);
    exp_t e;
    e.name = name; e.pc = p; e.rv = rv; e.rd = rd; e.tr = tr;
    return e;
  endfunction

  // Drive one cycle of stimulus on the falling edge and settle after the rising edge.
  task automatic apply(input stim_t s);
    @(negedge clk);
    reset = s.rst; stall = s.stall; halt = s.halt; resume = s.resume;
    branch_taken = s.br; branch_pc = s.bpc; sign_ext_imm = s.imm;
    jump = s.jump; jump_target = s.jt; req_ready = s.ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$]; exp_t e[$]; exp_t got;
    s.push_back(st(1,0,0,0,0,0,0,0,0,1)); e.push_back(ex("reset_0", 32'h0, 0, 0, 0));
    s.push_back(st(1,1,1,1,1,32'h100,0,1,32'h40,1)); e.push_back(ex("reset_dominant", 32'h0, 0, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = exp_q.pop_front();
      checks++;
      if ({pc, pc_plus4, req_valid, redirect, misalign_trap} !== {got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr}) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus4=%h rv=%b rd=%b trap=%b, want pc=%h pc_plus4=%h rv=%b rd=%b trap=%b",
                 got.name, pc, pc_plus4, req_valid, redirect, misalign_trap, got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr);
      end
    end
  endtask

  task automatic test_sequential();
    stim_t s[$]; exp_t e[$]; exp_t got;
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("boot_to_run", 32'h0, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("advance_4", 32'h4, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("advance_8", 32'h8, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("advance_12", 32'hC, 1, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = exp_q.pop_front();
      checks++;
      if ({pc, pc_plus4, req_valid, redirect, misalign_trap} !== {got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr}) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus4=%h rv=%b rd=%b trap=%b, want pc=%h pc_plus4=%h rv=%b rd=%b trap=%b",
                 got.name, pc, pc_plus4, req_valid, redirect, misalign_trap, got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr);
      end
    end
  endtask

  task automatic test_branch_and_jump();
    stim_t s[$]; exp_t e[$]; exp_t got;
    s.push_back(st(0,0,0,0,1,32'h100,32'hFFFF_FFFE,0,0,1)); e.push_back(ex("branch_neg_imm", 32'hFC, 1, 1, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("after_branch", 32'h100, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,0)); e.push_back(ex("redirect_one_cycle", 32'h100, 1, 0, 0));
    s.push_back(st(0,1,0,0,1,32'h100,0,1,32'h400,1)); e.push_back(ex("jump_beats_branch_stall", 32'h400, 1, 1, 0));
    s.push_back(st(0,1,0,0,0,0,0,0,0,1)); e.push_back(ex("stall_hold", 32'h400, 1, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = exp_q.pop_front();
      checks++;
      if ({pc, pc_plus4, req_valid, redirect, misalign_trap} !== {got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr}) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus4=%h rv=%b rd=%b trap=%b, want pc=%h pc_plus4=%h rv=%b rd=%b trap=%b",
                 got.name, pc, pc_plus4, req_valid, redirect, misalign_trap, got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr);
      end
    end
  endtask

  task automatic test_stall_halt();
    stim_t s[$]; exp_t e[$]; exp_t got;
    s.push_back(st(0,0,0,0,0,0,0,1,32'h20,1)); e.push_back(ex("jump_0x20", 32'h20, 1, 1, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,0)); e.push_back(ex("not_ready_1", 32'h20, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,0)); e.push_back(ex("not_ready_2", 32'h20, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("ready_again", 32'h24, 1, 0, 0));
    s.push_back(st(0,0,1,0,0,0,0,0,0,1)); e.push_back(ex("halt_enter", 32'h28, 0, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("halt_hold", 32'h28, 0, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,1,32'h200,1)); e.push_back(ex("halt_ignores_jump", 32'h28, 0, 0, 0));
    s.push_back(st(0,0,0,1,0,0,0,0,0,1)); e.push_back(ex("resume", 32'h28, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("resume_advance", 32'h2C, 1, 0, 0));
    s.push_back(st(0,0,1,0,0,0,0,1,32'h80,1)); e.push_back(ex("halt_with_jump", 32'h80, 0, 1, 0));
    s.push_back(st(0,0,1,1,0,0,0,0,0,1)); e.push_back(ex("resume_wins_in_halt", 32'h80, 1, 0, 0));
    s.push_back(st(0,0,1,1,0,0,0,0,0,1)); e.push_back(ex("halt_wins_in_run", 32'h84, 0, 0, 0));
    s.push_back(st(0,0,0,1,0,0,0,0,0,0)); e.push_back(ex("resume_again", 32'h84, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("advance_after_resume", 32'h88, 1, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = exp_q.pop_front();
      checks++;
      if ({pc, pc_plus4, req_valid, redirect, misalign_trap} !== {got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr}) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus4=%h rv=%b rd=%b trap=%b, want pc=%h pc_plus4=%h rv=%b rd=%b trap=%b",
                 got.name, pc, pc_plus4, req_valid, redirect, misalign_trap, got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr);
      end
    end
  endtask

  task automatic test_wrap_reset();
    stim_t s[$]; exp_t e[$]; exp_t got;
    s.push_back(st(0,0,0,0,0,0,0,1,32'hFFFF_FFFC,1)); e.push_back(ex("jump_top", 32'hFFFF_FFFC, 1, 1, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("wrap_to_0", 32'h0, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("after_wrap", 32'h4, 1, 0, 0));
    s.push_back(st(0,1,0,0,0,0,0,0,0,1)); e.push_back(ex("stall_before_reset", 32'h4, 1, 0, 0));
    s.push_back(st(1,1,0,0,0,0,0,1,32'h300,1)); e.push_back(ex("reset_mid_stall", 32'h0, 0, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("reboot_run", 32'h0, 1, 0, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("reboot_advance", 32'h4, 1, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = exp_q.pop_front();
      checks++;
      if ({pc, pc_plus4, req_valid, redirect, misalign_trap} !== {got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr}) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus4=%h rv=%b rd=%b trap=%b, want pc=%h pc_plus4=%h rv=%b rd=%b trap=%b",
                 got.name, pc, pc_plus4, req_valid, redirect, misalign_trap, got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$]; exp_t e[$]; exp_t got;
    s.push_back(st(0,0,0,0,0,0,0,1,32'h500,0)); e.push_back(ex("b2b_jump", 32'h500, 1, 1, 0));
    s.push_back(st(0,0,0,0,1,32'h500,32'h3,0,0,0)); e.push_back(ex("b2b_branch_fwd", 32'h510, 1, 1, 0));
    s.push_back(st(0,0,0,0,1,32'h510,32'hFFFF_FFFF,0,0,1)); e.push_back(ex("b2b_branch_back", 32'h510, 1, 1, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,1)); e.push_back(ex("b2b_advance", 32'h514, 1, 0, 0));
    s.push_back(st(0,0,0,0,1,32'h600,32'h4000_0001,0,0,1)); e.push_back(ex("imm_shift_truncate", 32'h608, 1, 1, 0));
    s.push_back(st(0,0,0,0,0,0,0,0,0,0)); e.push_back(ex("b2b_settle", 32'h608, 1, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = exp_q.pop_front();
      checks++;
      if ({pc, pc_plus4, req_valid, redirect, misalign_trap} !== {got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr}) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus4=%h rv=%b rd=%b trap=%b, want pc=%h pc_plus4=%h rv=%b rd=%b trap=%b",
                 got.name, pc, pc_plus4, req_valid, redirect, misalign_trap, got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr);
      end
    end
  endtask

  task automatic test_misalign();
    stim_t s[$]; exp_t e[$]; exp_t got;
`ifdef ALIGN_CHECK_EN
    s.push_back(st(0,0,0,0,0,0,0,1,32'h402,1)); e.push_back(ex("misalign_trap", 32'h608, 0, 0, 1));
    s.push_back(st(0,0,0,0,0,0,0,1,32'h400,1)); e.push_back(ex("trap_sticky", 32'h608, 0, 0, 1));
    s.push_back(st(0,0,0,1,0,0,0,0,0,1)); e.push_back(ex("trap_ignores_resume", 32'h608, 0, 0, 1));
`else
    s.push_back(st(0,0,0,0,0,0,0,1,32'h402,1)); e.push_back(ex("jump_aligned_down", 32'h400, 1, 1, 0));
    s.push_back(st(0,0,0,0,1,32'h101,32'h0,0,0,1)); e.push_back(ex("branch_aligned_down", 32'h104, 1, 1, 0));
`endif
    s.push_back(st(1,0,0,0,0,0,0,0,0,1)); e.push_back(ex("reset_clears_trap", 32'h0, 0, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = exp_q.pop_front();
      checks++;
      if ({pc, pc_plus4, req_valid, redirect, misalign_trap} !== {got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr}) begin
        errors++;
        $display("FAIL %s: got pc=%h pc_plus4=%h rv=%b rd=%b trap=%b, want pc=%h pc_plus4=%h rv=%b rd=%b trap=%b",
                 got.name, pc, pc_plus4, req_valid, redirect, misalign_trap, got.pc, got.pc + 32'd4, got.rv, got.rd, got.tr);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; halt = 1'b0; resume = 1'b0; branch_taken = 1'b0;
    jump = 1'b0; req_ready = 1'b0; branch_pc = '0; sign_ext_imm = '0; jump_target = '0;
    test_reset();
    test_sequential();
    test_branch_and_jump();
    test_stall_halt();
    test_wrap_reset();
    test_back_to_back();
    test_misalign();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
